// File: rtl/fifo_pkg.sv
// Shared definitions for the syn_fifo read-side streaming blocks.
// Holds the default word width, a beat record for benches and a framing sanity helper.
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 8;

    typedef struct packed {
        logic [FIFO_DATA_WIDTH-1:0] data;
        logic                       last;
    } rd_beat_t;

    // True when a packet length can be framed by a counter of cnt_width bits.
    function automatic bit pkt_len_fits(input longint pkt_len, input int cnt_width);
        return (pkt_len >= 64'sd1) && (pkt_len <= (64'sd1 << cnt_width));
    endfunction

endpackage

// File: rtl/stream_buf2.sv
// Two-entry register buffer with push/pop and occupancy count.
// The head entry is always visible on o_data; a simultaneous push and pop keeps the count.
module stream_buf2
    import fifo_pkg::*;
#(
    parameter int W = FIFO_DATA_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;

    logic w_push;
    logic w_pop;

    // Requests that cannot be honoured are dropped so the pointers never desynchronise.
    assign w_pop  = i_pop & (r_count != 2'd0);
    assign w_push = i_push & ((r_count != 2'd2) | w_pop);

    // NOTE: the two storage words are reset as well, because the head is a visible
    // output that must read zero out of reset; this is flop storage, not a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains syn_fifo through its rd_cs/rd_en pop port into a valid/ready stream,
// using credit-based pop issue into a 2-entry buffer and fixed-length packet framing.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int PKT_LEN    = 16,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_cs,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [CNT_WIDTH-1:0]  beat_idx,
    output logic                  idle
);

    if (!pkt_len_fits(64'(PKT_LEN), CNT_WIDTH)) begin : g_pkt_len_check
        $error("fifo_rd_stream: PKT_LEN must lie in 1..2**CNT_WIDTH");
    end

    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(PKT_LEN - 1);

    logic [1:0]           w_count;
    logic                 w_pop_out;
    logic [2:0]           w_occupancy;
    logic                 w_issue;
    logic                 r_inflight;
    logic [CNT_WIDTH-1:0] r_beat_idx;

    assign m_valid   = (w_count != 2'd0);
    assign w_pop_out = m_valid & m_ready;

    // Slots already promised: buffered words plus the word still coming back from the
    // FIFO, minus the one leaving this cycle. A pop is only issued while a slot is free.
    assign w_occupancy = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop_out};
    assign w_issue     = ~rst & en & ~fifo_empty & (w_occupancy < 3'd2);

    assign fifo_rd_en = w_issue;
    assign fifo_rd_cs = w_issue;

    // NOTE: sequential state uses non-blocking assignments so every flop samples the
    // pre-edge values of its neighbours, independent of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat_idx <= '0;
        end else if (w_pop_out) begin
            r_beat_idx <= (r_beat_idx == LAST_IDX) ? '0 : r_beat_idx + CNT_WIDTH'(1);
        end
    end

    // The FIFO's registered data_out is valid the cycle after the pop, so it is
    // captured whenever the previous cycle issued one.
    stream_buf2 #(
        .W (DATA_WIDTH)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_inflight),
        .i_data  (fifo_data),
        .i_pop   (w_pop_out),
        .o_data  (m_data),
        .o_count (w_count)
    );

    assign m_last   = m_valid & (r_beat_idx == LAST_IDX);
    assign beat_idx = r_beat_idx;
    assign idle     = (w_count == 2'd0) & ~r_inflight & (rst | ~en | fifo_empty);

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: a behavioural syn_fifo model feeds the DUT and
// a scoreboard checks every accepted beat against FIFO order and the packet framing rule.
module tb_fifo_rd_stream;
    import fifo_pkg::*;

    localparam int DW        = 8;
    localparam int PKT_LEN   = 4;
    localparam int CNT_WIDTH = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 en = 1'b0;
    logic                 m_ready = 1'b0;
    logic                 fifo_empty;
    logic [DW-1:0]        fifo_data = '0;
    logic                 fifo_rd_cs;
    logic                 fifo_rd_en;
    logic                 m_valid;
    logic [DW-1:0]        m_data;
    logic                 m_last;
    logic [CNT_WIDTH-1:0] beat_idx;
    logic                 idle;

    fifo_rd_stream #(
        .DATA_WIDTH (DW),
        .PKT_LEN    (PKT_LEN),
        .CNT_WIDTH  (CNT_WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_cs (fifo_rd_cs),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .beat_idx   (beat_idx),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    // Behavioural syn_fifo: written by the stimulus, popped with registered data_out.
    logic [DW-1:0] fifo_mem [1024];
    int            wp = 0;
    int            rp = 0;
    assign fifo_empty = (wp == rp);

    // Words popped from the FIFO that the stream still owes, in order.
    logic [DW-1:0] exp_q [$];
    int            beat_model = 0;
    int            beats_seen = 0;
    int            obs_idx [$];
    logic          obs_last [$];

    int checks = 0;
    int errors = 0;

    logic          s_rd_en, s_valid, s_last, s_idle;
    logic [DW-1:0] s_data;

    always @(posedge clk) begin
        if (fifo_rd_en && fifo_rd_cs && !fifo_empty) begin
            fifo_data <= fifo_mem[rp];
            exp_q.push_back(fifo_mem[rp]);
            rp <= rp + 1;
        end
    end

    task automatic push_word(input logic [DW-1:0] d);
        fifo_mem[wp] = d;
        wp = wp + 1;
    endtask

    // One clock: settle, snapshot, score any handshake, then advance to the next negedge.
    task automatic cycle();
        logic [DW-1:0] exp_d;
        logic          exp_last;
        #1;
        s_rd_en = fifo_rd_en;
        s_valid = m_valid;
        s_data  = m_data;
        s_last  = m_last;
        s_idle  = idle;
        checks++;
        if ((fifo_rd_en & fifo_empty) !== 1'b0) begin
            errors++;
            $display("FAIL pop_while_empty: rd_en=%b fifo_empty=%b at %0t", fifo_rd_en, fifo_empty, $time);
        end
        checks++;
        if (fifo_rd_cs !== fifo_rd_en) begin
            errors++;
            $display("FAIL rd_cs_vs_rd_en: rd_cs=%b rd_en=%b", fifo_rd_cs, fifo_rd_en);
        end
        checks++;
        if (dut.w_count > 2'd2) begin
            errors++;
            $display("FAIL buffer_count: got %0d, limit 2", dut.w_count);
        end
        if (m_valid && m_ready) begin
            beats_seen++;
            obs_idx.push_back(int'(beat_idx));
            obs_last.push_back(m_last);
            exp_last = (beat_model == PKT_LEN - 1);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got data %h, expected no beat", m_data);
            end else begin
                exp_d = exp_q.pop_front();
                if (m_data !== exp_d) begin
                    errors++;
                    $display("FAIL beat_data: got %h expected %h", m_data, exp_d);
                end
            end
            checks++;
            if (beat_idx !== CNT_WIDTH'(beat_model)) begin
                errors++;
                $display("FAIL beat_idx: got %0d expected %0d", beat_idx, beat_model);
            end
            checks++;
            if (m_last !== exp_last) begin
                errors++;
                $display("FAIL beat_last: got %b expected %b", m_last, exp_last);
            end
            beat_model = (beat_model + 1) % PKT_LEN;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int k = 0;
        en      = 1'b1;
        m_ready = 1'b1;
        while (k < budget && !(exp_q.size() == 0 && idle && fifo_empty)) begin
            cycle();
            k++;
        end
        checks++;
        if (k >= budget) begin
            errors++;
            $display("FAIL drain_timeout: %0d words still owed after %0d cycles", exp_q.size(), budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b1;
        m_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({fifo_rd_en, fifo_rd_cs, m_valid, m_last} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: rd_en/rd_cs/valid/last got %b%b%b%b expected 0000",
                     fifo_rd_en, fifo_rd_cs, m_valid, m_last);
        end
        checks++;
        if (m_data !== '0 || beat_idx !== '0) begin
            errors++;
            $display("FAIL reset_data: m_data=%h beat_idx=%0d expected 0/0", m_data, beat_idx);
        end
        checks++;
        if (idle !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle: got %b expected 1", idle);
        end
        en = 1'b0;
        m_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        for (int i = 1; i <= 4; i++) push_word(DW'(i));
        en = 1'b1;
        m_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            cycle();
            checks++;
            if (s_rd_en !== (c < 4)) begin
                errors++;
                $display("FAIL basic_rd_en c%0d: got %b expected %b", c, s_rd_en, (c < 4));
            end
            checks++;
            if (s_valid !== (c >= 2 && c < 6)) begin
                errors++;
                $display("FAIL basic_valid c%0d: got %b expected %b", c, s_valid, (c >= 2 && c < 6));
            end
            if (c >= 2 && c < 6) begin
                checks++;
                if (s_data !== DW'(c - 1)) begin
                    errors++;
                    $display("FAIL basic_data c%0d: got %h expected %h", c, s_data, DW'(c - 1));
                end
            end
        end
        checks++;
        if (idle !== 1'b1) begin
            errors++;
            $display("FAIL basic_idle: got %b expected 1", idle);
        end
        en = 1'b0;
    endtask

    task automatic test_back_pressure();
        int   pops = 0;
        int   start = beats_seen;
        logic prev_last = 1'b0;
        for (int i = 0; i < 8; i++) push_word(DW'(8'h10 + i));
        m_ready = 1'b0;
        en = 1'b1;
        for (int c = 0; c < 8; c++) begin
            cycle();
            pops += int'(s_rd_en);
            if (c >= 3) begin
                checks++;
                if (s_valid !== 1'b1 || s_data !== 8'h10) begin
                    errors++;
                    $display("FAIL bp_hold c%0d: valid=%b data=%h expected 1/10", c, s_valid, s_data);
                end
                if (c > 3) begin
                    checks++;
                    if (s_last !== prev_last) begin
                        errors++;
                        $display("FAIL bp_last_stable c%0d: got %b expected %b", c, s_last, prev_last);
                    end
                end
                prev_last = s_last;
            end
        end
        checks++;
        if (pops !== 2) begin
            errors++;
            $display("FAIL bp_pop_count: got %0d expected 2", pops);
        end
        drain(100);
        checks++;
        if (beats_seen - start !== 8) begin
            errors++;
            $display("FAIL bp_beats: got %0d expected 8", beats_seen - start);
        end
        en = 1'b0;
    endtask

    task automatic test_framing();
        int k = 0;
        int start = beats_seen;
        obs_idx.delete();
        obs_last.delete();
        for (int i = 0; i < 10; i++) push_word(DW'($urandom));
        en = 1'b1;
        while (beats_seen - start < 10 && k < 200) begin
            m_ready = ($urandom_range(0, 3) != 0);
            cycle();
            k++;
        end
        checks++;
        if (obs_idx.size() !== 10) begin
            errors++;
            $display("FAIL frame_beats: got %0d expected 10", obs_idx.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (obs_idx[i] !== i % 4 || obs_last[i] !== (i == 3 || i == 7)) begin
                    errors++;
                    $display("FAIL frame_seq beat%0d: idx=%0d last=%b expected %0d/%b",
                             i, obs_idx[i], obs_last[i], i % 4, (i == 3 || i == 7));
                end
            end
        end
        drain(100);
        en = 1'b0;
    endtask

    task automatic test_en_drop();
        int start = beats_seen;
        for (int i = 0; i < 3; i++) push_word(DW'($urandom));
        m_ready = 1'b1;
        en = 1'b1;
        cycle();
        en = 1'b0;
        for (int c = 0; c < 5; c++) begin
            cycle();
            checks++;
            if (s_rd_en !== 1'b0) begin
                errors++;
                $display("FAIL en_drop_rd_en c%0d: got %b expected 0", c, s_rd_en);
            end
        end
        checks++;
        if (beats_seen - start !== 1) begin
            errors++;
            $display("FAIL en_drop_inflight: got %0d beats expected 1", beats_seen - start);
        end
        drain(100);
        checks++;
        if (beats_seen - start !== 3) begin
            errors++;
            $display("FAIL en_drop_total: got %0d beats expected 3", beats_seen - start);
        end
        en = 1'b0;
    endtask

    task automatic test_empty_gaps();
        int start = beats_seen;
        en = 1'b1;
        for (int w = 0; w < 6; w++) begin
            push_word(DW'($urandom));
            repeat ($urandom_range(1, 4)) begin
                m_ready = ($urandom_range(0, 2) != 0);
                cycle();
            end
        end
        drain(100);
        checks++;
        if (beats_seen - start !== 6) begin
            errors++;
            $display("FAIL gaps_beats: got %0d expected 6", beats_seen - start);
        end
        en = 1'b0;
    endtask

    task automatic test_reset_mid();
        int start;
        for (int i = 0; i < 10; i++) push_word(DW'(8'h40 + i));
        en = 1'b1;
        m_ready = 1'b1;
        repeat (5) cycle();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({fifo_rd_en, fifo_rd_cs, m_valid, m_last} !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_ctrl: rd_en/rd_cs/valid/last got %b%b%b%b expected 0000",
                     fifo_rd_en, fifo_rd_cs, m_valid, m_last);
        end
        checks++;
        if (m_data !== '0 || beat_idx !== '0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL midrst_state: m_data=%h beat_idx=%0d idle=%b expected 0/0/1",
                     m_data, beat_idx, idle);
        end
        exp_q.delete();
        beat_model = 0;
        @(negedge clk);
        rst = 1'b0;
        start = beats_seen;
        drain(100);
        checks++;
        if (beats_seen - start !== 5) begin
            errors++;
            $display("FAIL midrst_fresh: got %0d beats expected 5", beats_seen - start);
        end
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_pressure();
        test_framing();
        test_en_drop();
        test_empty_gaps();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side drain stage placed directly downstream of the team's synchronous FIFO (syn_fifo).
- Converts the FIFO's pop interface into a valid/ready stream. The FIFO's pop interface is rd_cs/rd_en with a registered data_out that is valid one cycle after the pop.
- Sustains one beat per clock with back-pressure, using a 2-entry output buffer with credit accounting.
- Frames the stream into fixed-length packets via a beat counter that drives m_last.

Parameters:
- DATA_WIDTH, 8, width of the FIFO data word and of m_data.
- PKT_LEN, 16, beats per packet; legal range 1..2^CNT_WIDTH.
- CNT_WIDTH, 8, width of the beat counter and of beat_idx.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  drain enable; when low, no new FIFO pops are issued.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  DATA_WIDTH  FIFO registered data_out.
- fifo_rd_cs  out  1  FIFO read chip select.
- fifo_rd_en  out  1  FIFO read enable (pop).
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream ready.
- m_data  out  DATA_WIDTH  output beat data (head of buffer).
- m_last  out  1  final beat of the current packet.
- beat_idx  out  CNT_WIDTH  index of the current beat within its packet.
- idle  out  1  high when the buffer is empty, no pop is in flight, and en=0 or fifo_empty=1.

Behaviour:
- Reset: fifo_rd_cs=0, fifo_rd_en=0, m_valid=0, m_data=0, m_last=0, beat_idx=0, buffer count=0, inflight=0, idle=1. rst asserted mid-operation discards buffered and in-flight data; the pop in flight is lost by design.
- Pop issue (combinational): fifo_rd_en = fifo_rd_cs = en & !fifo_empty & (count + inflight - pop_out < 2).
  - pop_out = m_valid & m_ready.
  - Never pop while fifo_empty=1.
- inflight: register, set to fifo_rd_en each cycle.
- Read latency: 1 cycle. In the cycle where inflight=1, fifo_data is captured into the buffer tail at the next edge.
- Buffer:
  - 2-entry register FIFO holding {data}.
  - m_valid = (count != 0). m_data = head entry.
  - Push and pop in the same cycle: count unchanged, head advances.
  - Overflow is impossible by the credit rule. The bench asserts count <= 2 at all times.
- Throughput: with m_ready held high and the FIFO non-empty, one beat per clock after an initial latency of 2 cycles from the first pop (pop at edge N, capture at edge N+1, m_valid from N+1).
- Framing:
  - beat_idx increments on every pop_out.
  - When beat_idx == PKT_LEN-1 and pop_out occurs, beat_idx wraps to 0.
  - m_last = m_valid & (beat_idx == PKT_LEN-1).
  - PKT_LEN=1 gives m_last=1 on every beat.
- Back-pressure: m_data, m_last and m_valid remain stable while m_valid & !m_ready.
- en deassert: stops new pops only. The in-flight word is still captured and buffered words still drain.
- Counter width: beat_idx compares against PKT_LEN-1 truncated to CNT_WIDTH. A parameter check (elaboration error) is required if PKT_LEN > 2^CNT_WIDTH.

Decomposition:
- Shared package fifo_pkg: DATA_WIDTH default constant, and an rd_stream beat struct {data, last} for benches.
- Natural sub-module: stream_buf2 (2-entry register buffer with push/pop/count). The top level keeps pop-issue, inflight, and beat-counter logic.

Test Plan:
- Reset then en=1 with FIFO preloaded with 0x01..0x04, m_ready=1:
  - fifo_rd_en high for 4 consecutive cycles.
  - m_data = 01,02,03,04 on 4 consecutive cycles, starting 2 cycles after the first pop.
  - idle=1 afterwards.
- Back-pressure with FIFO holding 0x10..0x17 and m_ready=0 from the start:
  - Exactly 2 pops issued, then fifo_rd_en=0.
  - m_data holds 0x10.
  - On m_ready=1, the stream resumes 10..17 with no loss or duplication.
- Framing, PKT_LEN=4, with 10 beats streamed:
  - m_last on beats 3 and 7 only.
  - beat_idx sequence 0,1,2,3,0,1,2,3,0,1.
- en dropped in the cycle after a pop:
  - The in-flight word is still delivered.
  - No further fifo_rd_en while en=0.
- Empty boundary, with FIFO delivering single words separated by gaps:
  - fifo_rd_en never asserts while fifo_empty=1.
  - Each word appears exactly once.
- rst asserted while count=2 and inflight=1:
  - All outputs return to reset values asynchronously.
  - After release, fresh data streams with beat_idx=0.
